// File: rtl/regbank_mp.sv
// Multi-port register bank: two write ports with write-through forwarding, NUM_RD 2-stage
// registered read ports, a per-register busy scoreboard and hold-snoop of held read outputs.
module regbank_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic                     hold,
    input  logic                     clear,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [1:0]               wr_we,
    input  logic [2*AW-1:0]          wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [AW-1:0]     a_q    [NUM_RD];
    logic [AW-1:0]     a_d    [NUM_RD];
    logic [AW-1:0]     o_q    [NUM_RD];
    logic [AW-1:0]     o_d    [NUM_RD];
    logic [DATA_W-1:0] data_q [NUM_RD];
    logic [DATA_W-1:0] data_d [NUM_RD];
    logic [NUM_RD-1:0] rbusy_q, rbusy_d;

    logic [AW-1:0]     waddr [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        wr_ok;
    logic              rsv_ok;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            waddr[k] = wr_addr[k*AW +: AW];
            wdata[k] = wr_data[k*DATA_W +: DATA_W];
            wr_ok[k] = wr_we[k] && !((ZERO_REG != 0) && (waddr[k] == '0));
        end
        rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    end

    // Register file and scoreboard next state; port 1 applied last so it wins, and the
    // reservation is applied after the write clears so a same-cycle set wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < 2; k++) begin
            if (wr_ok[k]) begin
                regs_d[waddr[k]] = wdata[k];
                busy_d[waddr[k]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            a_d[p]     = a_q[p];
            o_d[p]     = o_q[p];
            data_d[p]  = data_q[p];
            rbusy_d[p] = rbusy_q[p];
            if (clear) begin
                a_d[p]     = '0;
                o_d[p]     = '0;
                data_d[p]  = '0;
                rbusy_d[p] = 1'b0;
            end else if (!hold) begin
                a_d[p]     = rd_addr[p*AW +: AW];
                o_d[p]     = a_q[p];
                rbusy_d[p] = busy_d[a_q[p]];
                if (wr_ok[1] && (waddr[1] == a_q[p])) begin
                    data_d[p] = wdata[1];
                end else if (wr_ok[0] && (waddr[0] == a_q[p])) begin
                    data_d[p] = wdata[0];
                end else begin
                    data_d[p] = regs_q[a_q[p]];
                end
                if ((ZERO_REG != 0) && (a_q[p] == '0)) begin
                    data_d[p] = '0;
                end
            end else begin
                // Held: refresh the output if its source register is being written.
                if (wr_ok[1] && (waddr[1] == o_q[p])) begin
                    data_d[p]  = wdata[1];
                    rbusy_d[p] = busy_d[o_q[p]];
                end else if (wr_ok[0] && (waddr[0] == o_q[p])) begin
                    data_d[p]  = wdata[0];
                    rbusy_d[p] = busy_d[o_q[p]];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            for (int p = 0; p < NUM_RD; p++) begin
                a_q[p]    <= '0;
                o_q[p]    <= '0;
                data_q[p] <= '0;
            end
            rbusy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            for (int p = 0; p < NUM_RD; p++) begin
                a_q[p]    <= a_d[p];
                o_q[p]    <= o_d[p];
                data_q[p] <= data_d[p];
            end
            rbusy_q <= rbusy_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p*DATA_W +: DATA_W] = data_q[p];
        end
    end

    assign rd_busy  = rbusy_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Directed-vector bench for regbank_mp with default parameters (32-bit, 16 regs, 2 read ports).
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  rd_addr = '0;
    logic        hold = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_we = '0;
    logic [7:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic [15:0] busy_vec;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    regbank_mp dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr  (rd_addr),
        .hold     (hold),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_we    (wr_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [31:0] d);
        wr_we[k]           = 1'b1;
        wr_addr[k*4 +: 4]  = a;
        wr_data[k*32 +: 32] = d;
    endtask

    initial begin
        // Reset
        #1 reset_n = 1'b0;
        #2;
        check_eq("rst_rd_data", rd_data, 64'h0);
        check_eq("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
        check_eq("rst_busy_vec", {48'h0, busy_vec}, 64'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // r5 = 0x1234 via port 0, then read r5 on port 0
        wr(0, 4'd5, 32'h1234);
        tick();
        wr_we = '0;
        rd_addr[3:0] = 4'd5;
        tick();
        check_eq("r5_latency1", {32'h0, rd_data[31:0]}, 64'h0);
        tick();
        check_eq("r5_read", {32'h0, rd_data[31:0]}, 64'h1234);

        // Write to r0 is ignored
        wr(0, 4'd0, 32'hDEAD);
        rd_addr[3:0] = 4'd0;
        tick();
        wr_we = '0;
        tick();
        tick();
        check_eq("r0_zero", {32'h0, rd_data[31:0]}, 64'h0);

        // Same-cycle double write of r3, port 1 wins, forwarded to a capture in that cycle
        rd_addr[3:0] = 4'd3;
        tick();
        wr(0, 4'd3, 32'hAAAA);
        wr(1, 4'd3, 32'hBBBB);
        tick();
        wr_we = '0;
        check_eq("r3_fwd_p1wins", {32'h0, rd_data[31:0]}, 64'hBBBB);
        rd_addr[7:4] = 4'd3;
        tick();
        tick();
        check_eq("r3_stored", {32'h0, rd_data[63:32]}, 64'hBBBB);

        // r7 read on both ports, written in the stage-2 cycle
        rd_addr = {4'd7, 4'd7};
        tick();
        wr(0, 4'd7, 32'h55);
        tick();
        wr_we = '0;
        check_eq("r7_fwd_both", rd_data, {32'h55, 32'h55});

        // Hold with o_reg = r4 on both ports; r9 queued on port 0
        rd_addr = {4'd4, 4'd4};
        wr(1, 4'd9, 32'h909);
        tick();
        wr_we = '0;
        rd_addr[3:0] = 4'd9;
        tick();
        check_eq("r4_before_hold", rd_data, 64'h0);
        hold = 1'b1;
        rd_addr[3:0] = 4'd2;
        tick();
        check_eq("hold_c1", rd_data, 64'h0);
        wr(1, 4'd4, 32'h99);
        tick();
        wr_we = '0;
        check_eq("hold_snoop", rd_data, {32'h99, 32'h99});
        tick();
        check_eq("hold_c3", rd_data, {32'h99, 32'h99});
        hold = 1'b0;
        tick();
        check_eq("release_queued", {32'h0, rd_data[31:0]}, 64'h909);
        tick();
        check_eq("release_next", {32'h0, rd_data[31:0]}, 64'h0);

        // Scoreboard
        rsv_en = 1'b1;
        rsv_addr = 4'd6;
        rd_addr[3:0] = 4'd6;
        tick();
        rsv_en = 1'b0;
        check_eq("rsv_busy_vec", {48'h0, busy_vec}, 64'h40);
        tick();
        check_eq("rd_busy_r6", {62'h0, rd_busy}, 64'h1);
        wr(0, 4'd6, 32'h66);
        tick();
        wr_we = '0;
        check_eq("wr_clears_busy", {48'h0, busy_vec}, 64'h0);
        check_eq("rd_busy_post_wr", {62'h0, rd_busy}, 64'h0);
        check_eq("r6_fwd", {32'h0, rd_data[31:0]}, 64'h66);
        rsv_en = 1'b1;
        wr(1, 4'd6, 32'h77);
        tick();
        wr_we = '0;
        check_eq("set_wins_vec", {48'h0, busy_vec}, 64'h40);
        check_eq("set_wins_rd_busy", {62'h0, rd_busy}, 64'h1);
        rsv_addr = 4'd0;
        tick();
        rsv_en = 1'b0;
        check_eq("rsv_r0_ignored", {48'h0, busy_vec}, 64'h40);

        // Clear overrides hold
        hold = 1'b1;
        clear = 1'b1;
        tick();
        check_eq("clear_data", rd_data, 64'h0);
        check_eq("clear_busy", {62'h0, rd_busy}, 64'h0);
        hold = 1'b0;
        clear = 1'b0;
        tick();
        check_eq("post_clear_bubble", {32'h0, rd_data[31:0]}, 64'h0);
        tick();
        check_eq("post_clear_r6", {32'h0, rd_data[31:0]}, 64'h77);
        check_eq("post_clear_busy", {62'h0, rd_busy}, 64'h1);

        // Asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_data", rd_data, 64'h0);
        check_eq("async_rst_busy", {62'h0, rd_busy}, 64'h0);
        check_eq("async_rst_vec", {48'h0, busy_vec}, 64'h0);
        #1 reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
